// File: rtl/mem_fill_arbiter_if.sv
// Bundle of client handshakes and memory port signals seen by mem_fill_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_fill_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // I-cache fill client
  logic              i_req;
  logic              i_rd;
  logic [ADDR_W-1:0] i_addr;
  logic              i_grant;
  logic [DATA_W-1:0] i_data;
  logic              i_data_valid;
  // D-cache fill client and write-through store path
  logic              d_req;
  logic              d_rd;
  logic [ADDR_W-1:0] d_addr;
  logic              d_grant;
  logic [DATA_W-1:0] d_data;
  logic              d_data_valid;
  logic              d_wr;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              d_wr_done;
  // Shared pipelined memory
  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_data_valid;

  modport slave (
    input  i_req, i_rd, i_addr, d_req, d_rd, d_addr,
           d_wr, d_wr_addr, d_wr_data, mem_data_in, mem_data_valid,
    output i_grant, i_data, i_data_valid, d_grant, d_data, d_data_valid,
           d_wr_done, mem_enable, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_rd, i_addr, d_req, d_rd, d_addr,
           d_wr, d_wr_addr, d_wr_data, mem_data_in, mem_data_valid,
    input  i_grant, i_data, i_data_valid, d_grant, d_data, d_data_valid,
           d_wr_done, mem_enable, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the single pipelined data memory between the I-fill and D-fill
// FSMs, inserts single-cycle D-side write-through stores, and steers each
// returning read word to its issuer through an in-flight owner tag pipeline.
module mem_fill_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_fill_arbiter_if.slave  arb
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, WRITE} state_e;

  state_e             state_q, state_d;

  logic               mem_en_c;
  logic               mem_wr_c;
  logic [ADDR_W-1:0]  mem_addr_c;
  logic [DATA_W-1:0]  mem_wdata_c;
  logic               wr_done_c;

  // Tag pipeline: valid marks a read in flight, owner is 1 for D, 0 for I
  logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0] tag_own_q, tag_own_d;
  logic               rd_issue;
  logic               rd_owner;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: stores win in IDLE, D beats I, grants held until released, round-robin on release
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (arb.d_wr)       state_d = WRITE;
        else if (arb.d_req) state_d = GNT_D;
        else if (arb.i_req) state_d = GNT_I;
      end
      GNT_I: begin
        if (!arb.i_req) state_d = arb.d_req ? GNT_D : IDLE;
      end
      GNT_D: begin
        if (!arb.d_req) begin
          if (arb.i_req)     state_d = GNT_I;
          else if (arb.d_wr) state_d = WRITE;
          else               state_d = IDLE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port drive: owner's read strobe passes through; the other client's strobe is ignored
  always_comb begin
    mem_en_c    = 1'b0;
    mem_wr_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    wr_done_c   = 1'b0;
    unique case (state_q)
      GNT_I: begin
        mem_en_c   = arb.i_rd;
        mem_addr_c = arb.i_rd ? arb.i_addr : '0;
      end
      GNT_D: begin
        mem_en_c   = arb.d_rd;
        mem_addr_c = arb.d_rd ? arb.d_addr : '0;
      end
      WRITE: begin
        mem_en_c    = 1'b1;
        mem_wr_c    = 1'b1;
        mem_addr_c  = arb.d_wr_addr;
        mem_wdata_c = arb.d_wr_data;
        wr_done_c   = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_issue = mem_en_c & ~mem_wr_c;
  assign rd_owner = (state_q == GNT_D);

  // Tag next-state: load the current read's owner at stage 0 and shift toward the tail
  always_comb begin
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = rd_issue;
    tag_own_d[0] = rd_owner;
    for (int k = 1; k < MEM_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_own_d[k] = tag_own_q[k-1];
    end
  end

  // Tag valid bits are cleared on reset so late memory returns are discarded
  always_ff @(posedge clk) begin
    if (rst) tag_vld_q <= '0;
    else     tag_vld_q <= tag_vld_d;
  end

  // Tag owner bits only matter when the matching valid bit is set
  always_ff @(posedge clk) begin
    tag_own_q <= tag_own_d;
  end

  assign arb.i_grant      = (state_q == GNT_I);
  assign arb.d_grant      = (state_q == GNT_D);
  assign arb.d_wr_done    = wr_done_c;
  assign arb.mem_enable   = mem_en_c;
  assign arb.mem_wr       = mem_wr_c;
  assign arb.mem_addr     = mem_addr_c;
  assign arb.mem_wdata    = mem_wdata_c;

  assign arb.i_data       = arb.mem_data_in;
  assign arb.d_data       = arb.mem_data_in;
  assign arb.i_data_valid = arb.mem_data_valid & tag_vld_q[MEM_LAT-1] & ~tag_own_q[MEM_LAT-1];
  assign arb.d_data_valid = arb.mem_data_valid & tag_vld_q[MEM_LAT-1] &  tag_own_q[MEM_LAT-1];

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Sits between the I-cache and D-cache fill FSMs and the single shared pipelined data memory.
- Grants the memory port to one client at a time and forwards that client's read strobes and addresses.
- Routes each returning word back to the client that issued it, using an in-flight tag pipeline.
- Also carries single-word D-side write-through stores.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 4, cycles from mem_enable (read) to mem_data_valid; memory is fully pipelined and returns in order

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- i_req  in  1  I-fill FSM requests/holds the port (its busy signal)
- i_rd  in  1  I-fill read strobe, one word per cycle
- i_addr  in  ADDR_W  I-fill word address
- d_req  in  1  D-fill FSM requests/holds the port
- d_rd  in  1  D-fill read strobe
- d_addr  in  ADDR_W  D-fill word address
- d_wr  in  1  D-side store request (level, held until d_wr_done)
- d_wr_addr  in  ADDR_W  store address
- d_wr_data  in  DATA_W  store data
- i_grant  out  1  I client owns the port (registered)
- d_grant  out  1  D client owns the port (registered)
- i_data  out  DATA_W  returned word (= mem_data_in)
- i_data_valid  out  1  returned word belongs to I
- d_data  out  DATA_W  returned word (= mem_data_in)
- d_data_valid  out  1  returned word belongs to D
- d_wr_done  out  1  one-cycle pulse: store issued to memory
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_data_in  in  DATA_W  memory read data
- mem_data_valid  in  1  memory read data valid

Behaviour:
- States: IDLE, GNT_I, GNT_D, WRITE. Reset → IDLE.
- Reset values: i_grant = 0, d_grant = 0, d_wr_done = 0, mem_enable = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0. Tag pipeline is cleared, so all data_valid outputs are 0.
- IDLE priority, evaluated per cycle: d_wr → WRITE; else d_req → GNT_D; else i_req → GNT_I.
- Grants are registered: the grant output rises the cycle after the request is seen in IDLE.
- GNT_x:
  - mem_enable = x_rd, mem_wr = 0, mem_addr = x_addr.
  - The other client's rd is ignored. Bench flags rd without grant as a protocol error.
  - Stay while x_req = 1; no preemption.
  - When x_req = 0: go to the other grant if the other client's req = 1 (round-robin on release); else go to WRITE if d_wr = 1 (D release only); else IDLE.
  - The grant drops the cycle after x_req falls.
- WRITE lasts 1 cycle:
  - mem_enable = 1, mem_wr = 1, mem_addr = d_wr_addr, mem_wdata = d_wr_data, d_wr_done = 1.
  - Next state: IDLE.
  - A store arriving during a grant waits until that grant is released.
- Tag pipeline: MEM_LAT stages of {valid, owner}.
  - Stage 0 is loaded each cycle with {mem_enable & ~mem_wr, owner}; stages then shift.
  - At the tail: i_data_valid = mem_data_valid & tail.valid & (tail.owner == I); d_data_valid likewise for D.
  - Returns are routed correctly even after the grant has moved to the other client.
  - Back-to-back reads by different owners never collide, because the memory returns in order, one word per cycle.
  - mem_data_valid with an invalid tail is dropped (no valid output).
- Simultaneous events:
  - d_req and i_req in the same IDLE cycle → D wins.
  - d_wr and d_req together → WRITE first, then GNT_D.
- Reset mid-operation: returns to IDLE; in-flight tags are discarded, so late mem_data_valid pulses produce no client valid.
- Memory outputs are combinational from state, registered grant and client inputs. mem_addr and mem_wdata are 0 when mem_enable = 0.

Test Plan:
- Reset → IDLE, outputs 0. i_req=1 → i_grant=1 next cycle. 8 i_rd strobes at addrs 0x1230..0x123E step 2 → mem_enable for 8 cycles; i_data_valid high exactly 8 cycles, starting MEM_LAT=4 cycles after the first strobe.
- i_req and d_req rise together → d_grant first. D drops req after 8 reads → i_grant on the next cycle. Remaining D returns assert d_data_valid only, never i_data_valid.
- d_wr with addr 0x0040, data 0xBEEF in IDLE → one cycle of mem_enable=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, d_wr_done=1. No data_valid pulses follow.
- d_wr asserted during GNT_I → no write while i_grant=1; write issues the cycle after I releases; d_wr_done pulses once.
- rst asserted 2 cycles after the 3rd I read → outputs return to reset values; subsequent mem_data_valid pulses give i_data_valid=0.
- d_rd toggled while only i_grant=1 → mem_addr always tracks i_addr; no D tag enters the pipeline.
